fetch_stage: RTL and testbench

- Pipelined instruction-fetch stage for the MIPS core. It owns the PC register, next-PC selection and the IF/ID pipeline register.
- Drives the combinational instruction memory address. Captures the returned word together with PC+4 for the decode stage.
- Accepts stall requests from the hazard unit, and redirect/flush requests from the ID-stage branch/jump logic.

---
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Fetch runs only in the run state; redirects force word alignment and flag misaligned targets.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] imem_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_inst_o,
  output logic        if_id_valid_o,
  output logic        misalign_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [31:0] PcStep = PC_STEP[31:0];

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic [31:0] pc_plus;

  assign pc_plus = pc_q + PcStep;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (!start_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Defaults describe a bubble with the PC held; only a running, enabled fetch changes that.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = NOP_INST;
    pc4_d   = '0;
    valid_d = 1'b0;
    mis_d   = mis_q;
    case (state_q)
      StRun: begin
        if (!start_i) begin
          pc_d = pc_q;
        end else if (stall_i) begin
          inst_d  = inst_q;
          pc4_d   = pc4_q;
          valid_d = valid_q;
        end else if (jump_i) begin
          pc_d  = {jump_target_i[31:2], 2'b00};
          mis_d = mis_q | (|jump_target_i[1:0]);
        end else if (branch_i) begin
          pc_d  = {branch_target_i[31:2], 2'b00};
          mis_d = mis_q | (|branch_target_i[1:0]);
        end else if (flush_i) begin
          pc_d = pc_plus;
        end else begin
          pc_d    = pc_plus;
          inst_d  = imem_data_i;
          pc4_d   = pc_plus;
          valid_d = 1'b1;
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_inst_o  = inst_q;
  assign if_id_valid_o = valid_q;
  assign misalign_o    = mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model pushes expected state per edge,
// a monitor pops and compares after each rising edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stall, flush, branch, jump;
  logic [31:0] branch_target, jump_target, imem_data, imem_addr;
  logic [31:0] pc, pc4, inst;
  logic        valid, mis;

  logic        rst1, start1;
  logic [31:0] imem_data1, imem_addr1, pc1, pc41, inst1;
  logic        valid1, mis1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_000A;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_data  = mem(imem_addr);
  assign imem_data1 = mem(imem_addr1);

  fetch_stage dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_i(branch), .branch_target_i(branch_target), .jump_i(jump),
    .jump_target_i(jump_target), .imem_data_i(imem_data), .imem_addr_o(imem_addr),
    .pc_o(pc), .if_id_pc4_o(pc4), .if_id_inst_o(inst), .if_id_valid_o(valid),
    .misalign_o(mis)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst1), .start_i(start1), .stall_i(1'b0), .flush_i(1'b0),
    .branch_i(1'b0), .branch_target_i(32'h0), .jump_i(1'b0), .jump_target_i(32'h0),
    .imem_data_i(imem_data1), .imem_addr_o(imem_addr1), .pc_o(pc1), .if_id_pc4_o(pc41),
    .if_id_inst_o(inst1), .if_id_valid_o(valid1), .misalign_o(mis1)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model state
  bit          m_run = 0;
  logic [31:0] m_pc = 32'h0, m_inst = NOP, m_pc4 = 32'h0;
  bit          m_valid = 0, m_mis = 0;

  task automatic bubble();
    m_inst = NOP; m_pc4 = 32'h0; m_valid = 0;
  endtask

  task automatic step(input bit r, input bit st, input bit stl, input bit fl, input bit br,
                      input logic [31:0] bt, input bit jp, input logic [31:0] jt);
    exp_t e;
    @(negedge clk);
    rst = r; start = st; stall = stl; flush = fl;
    branch = br; branch_target = bt; jump = jp; jump_target = jt;
    if (r) begin
      m_run = 0; m_pc = 32'h0; m_mis = 0; bubble();
    end else if (!m_run) begin
      bubble(); m_run = st;
    end else if (!st) begin
      bubble(); m_run = 0;
    end else if (stl) begin
      m_run = 1;
    end else if (jp || br) begin
      logic [31:0] t;
      t = jp ? jt : bt;
      if (t % 4 != 0) m_mis = 1;
      m_pc = t - (t % 4);
      bubble();
    end else if (fl) begin
      m_pc = m_pc + 4; bubble();
    end else begin
      m_inst = mem(m_pc); m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
    end
    e.pc = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid; e.mis = m_mis;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc", pc, e.pc);
      chk("imem_addr", imem_addr, e.pc);
      chk("if_id_inst", inst, e.inst);
      chk("if_id_pc4", pc4, e.pc4);
      chk("if_id_valid", {31'h0, valid}, {31'h0, e.valid});
      chk("misalign", {31'h0, mis}, {31'h0, e.mis});
    end
  end

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic plain();
    step(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    rst = 1; start = 0; stall = 0; flush = 0; branch = 0; jump = 0;
    branch_target = 0; jump_target = 0;
    rst1 = 1; start1 = 0;

    // Wrap boundary on a second instance reset to 0xFFFF_FFFC
    @(negedge clk); rst1 = 1; start1 = 0;
    @(negedge clk); rst1 = 0; start1 = 1;
    @(negedge clk);
    after_edge();
    chk("wrap_pc", pc1, 32'h0);
    chk("wrap_pc4", pc41, 32'h0);
    chk("wrap_inst", inst1, mem(32'hFFFF_FFFC));
    chk("wrap_valid", {31'h0, valid1}, 32'h1);

    // Plan 1: reset, start, first two fetches
    step(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    plain();
    plain();
    after_edge();
    chk("p1_inst0", inst, 32'h2008_0005);
    chk("p1_pc4_0", pc4, 32'h4);
    chk("p1_valid0", {31'h0, valid}, 32'h1);
    plain();
    after_edge();
    chk("p1_inst1", inst, 32'h2009_000A);
    chk("p1_pc4_1", pc4, 32'h8);
    chk("p1_pc", pc, 32'h8);
    // Plan 2: stall at 0x10
    plain(); plain();
    step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
    step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
    plain();
    // Plan 3: move to 0x20, then branch+flush to 0x40
    step(0, 1, 0, 0, 0, 32'h0, 1, 32'h20);
    step(0, 1, 0, 1, 1, 32'h40, 0, 32'h0);
    plain();
    after_edge();
    chk("p3_inst", inst, mem(32'h40));
    chk("p3_pc4", pc4, 32'h44);
    // Plan 4: jump beats branch; stall beats both
    step(0, 1, 0, 0, 1, 32'h80, 1, 32'h100);
    step(0, 1, 1, 0, 1, 32'h80, 1, 32'h200);
    after_edge();
    chk("p4_pc", pc, 32'h100);
    // Plan 5: misaligned redirect is sticky
    step(0, 1, 0, 0, 1, 32'h43, 0, 32'h0);
    plain(); plain(); plain();
    // Plan 6: reset during stall, then dropping start in run
    step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
    step(1, 1, 1, 0, 0, 32'h0, 0, 32'h0);
    step(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    plain(); plain();
    step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);

    // Randomised phase
    for (int i = 0; i < 600; i++) begin
      logic [31:0] bt, jt;
      bt = {$urandom_range(0, 255), 2'b00} & 32'h0000_03FF;
      jt = {$urandom_range(0, 255), 2'b00} & 32'h0000_03FF;
      if ($urandom_range(0, 15) == 0) bt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) jt[1:0] = 2'($urandom_range(1, 3));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 6) == 0, bt, $urandom_range(0, 9) == 0, jt);
    end

    after_edge();
    after_edge();
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
